crc_stream_gen: RTL and testbench

CRC_STREAM_GEN -- requirements
Module: crc_stream_gen

---
 rtl/crc_stream_gen_if.sv | 39 +++
 rtl/crc_stream_gen.sv | 124 ++++++++++++
 tb/tb_crc_stream_gen.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_stream_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : crc_stream_gen_if
// Description : Stream/result bundle for crc_stream_gen.
//               Input side : in_valid/in_ready handshake carrying in_data,
//                            in_sop, in_eop and in_nbytes.
//               Output side: crc_valid/crc_ready handshake carrying crc_out,
//                            plus the crc_err protocol-violation pulse.
//               master = stream source / result sink, slave = CRC engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface crc_stream_gen_if #(
    parameter int DATA_W = 32,
    parameter int CRC_W  = 16
);
    localparam int NB_W = $clog2(DATA_W / 8) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sop;
    logic              in_eop;
    logic [NB_W-1:0]   in_nbytes;
    logic              crc_valid;
    logic              crc_ready;
    logic [CRC_W-1:0]  crc_out;
    logic              crc_err;

    modport master (
        output in_valid, in_data, in_sop, in_eop, in_nbytes, crc_ready,
        input  in_ready, crc_valid, crc_out, crc_err
    );

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, in_nbytes, crc_ready,
        output in_ready, crc_valid, crc_out, crc_err
    );
endinterface
`default_nettype wire

// File: rtl/crc_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : crc_stream_gen
// Description : Packet CRC generator. One beat of DATA_W bits is folded into
//               the accumulator per cycle (MSB-first, normal-form POLY). The
//               finished CRC (acc ^ XOR_OUT) is held until consumed.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-low reset
//               bus  - crc_stream_gen_if.slave (input beats, result, error)
// Revision    : 1.0 - initial release
// ============================================================================
module crc_stream_gen #(
    parameter int               DATA_W  = 32,
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h100B,
    parameter logic [CRC_W-1:0] INIT    = '1,
    parameter logic [CRC_W-1:0] XOR_OUT = '0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    crc_stream_gen_if.slave   bus
);

    localparam int NBYTES = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CRC_W-1:0] acc_q,   acc_d;
    logic             rdy_q,   rdy_d;
    logic             err_q,   err_d;

    logic             accept;
    int               nbits;
    logic [CRC_W-1:0] crc_new;

    // Fully unrolled bit-serial update; bits past nbits leave the CRC alone,
    // which is how a short eop beat drops its trailing bytes.
    function automatic logic [CRC_W-1:0] crc_update(
        input logic [CRC_W-1:0]  seed,
        input logic [DATA_W-1:0] data,
        input int                nb
    );
        logic [CRC_W-1:0] c;
        logic             fb;
        c = seed;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < nb) begin
                fb = data[DATA_W-1-i] ^ c[CRC_W-1];
                c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
            end
        end
        return c;
    endfunction

    // Byte count only matters on the eop beat; 0 or out-of-range means full.
    always_comb begin
        nbits = DATA_W;
        if (bus.in_eop && (bus.in_nbytes != '0) && (int'(bus.in_nbytes) <= NBYTES))
            nbits = 8 * int'(bus.in_nbytes);
    end

    assign accept  = bus.in_valid && rdy_q;
    // A sop beat always restarts from INIT, whatever state it arrives in.
    assign crc_new = crc_update(bus.in_sop ? INIT : acc_q, bus.in_data, nbits);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.in_sop) begin
                        acc_d   = crc_new;
                        state_d = bus.in_eop ? S_HOLD : S_ACCUM;
                    end else begin
                        err_d = 1'b1;   // orphan beat is dropped
                    end
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    err_d   = bus.in_sop;   // restart abandons the old packet
                    acc_d   = crc_new;
                    state_d = bus.in_eop ? S_HOLD : S_ACCUM;
                end
            end
            S_HOLD: begin
                if (bus.crc_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Registered so it stays low through the consume cycle and during
        // reset, rising only on the first edge after reset is released.
        rdy_d = (state_d != S_HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= INIT;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.crc_valid = (state_q == S_HOLD);
    assign bus.crc_out   = (state_q == S_HOLD) ? (acc_q ^ XOR_OUT) : '0;
    assign bus.crc_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_crc_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_stream_gen
// Description : Self-checking bench. Three engines with different INIT and
//               XOR_OUT share one stimulus stream; a byte-queue reference
//               model predicts each result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_stream_gen;

    localparam int DATA_W = 32;
    localparam int CRC_W  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data = '0;
    logic        sop = 1'b0;
    logic        eop = 1'b0;
    logic [2:0]  nbytes = '0;
    logic        cready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    crc_stream_gen_if #(.DATA_W(DATA_W), .CRC_W(CRC_W)) bus_a ();
    crc_stream_gen_if #(.DATA_W(DATA_W), .CRC_W(CRC_W)) bus_b ();
    crc_stream_gen_if #(.DATA_W(DATA_W), .CRC_W(CRC_W)) bus_c ();

    assign bus_a.in_valid = valid;  assign bus_b.in_valid = valid;  assign bus_c.in_valid = valid;
    assign bus_a.in_data  = data;   assign bus_b.in_data  = data;   assign bus_c.in_data  = data;
    assign bus_a.in_sop   = sop;    assign bus_b.in_sop   = sop;    assign bus_c.in_sop   = sop;
    assign bus_a.in_eop   = eop;    assign bus_b.in_eop   = eop;    assign bus_c.in_eop   = eop;
    assign bus_a.in_nbytes = nbytes; assign bus_b.in_nbytes = nbytes; assign bus_c.in_nbytes = nbytes;
    assign bus_a.crc_ready = cready; assign bus_b.crc_ready = cready; assign bus_c.crc_ready = cready;

    crc_stream_gen #(.DATA_W(DATA_W), .CRC_W(CRC_W), .INIT(16'h0000), .XOR_OUT(16'h0000))
        u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    crc_stream_gen #(.DATA_W(DATA_W), .CRC_W(CRC_W))
        u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    crc_stream_gen #(.DATA_W(DATA_W), .CRC_W(CRC_W), .INIT(16'h1D0F), .XOR_OUT(16'hFFFF))
        u_dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    // ---------------- reference model: bytes of the current packet ----------
    logic [7:0] pkt[$];
    bit         in_pkt = 1'b0;

    function automatic logic [15:0] model_crc(input logic [15:0] init);
        logic [15:0] c;
        logic        fb;
        c = init;
        foreach (pkt[j]) begin
            for (int k = 7; k >= 0; k--) begin
                fb = pkt[j][k] ^ c[15];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
            end
        end
        return c;
    endfunction

    function automatic int eff_bytes(input logic [2:0] nb);
        return (nb == 3'd0 || nb > 3'd4) ? 4 : int'(nb);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic s, input logic e,
                             input logic [2:0] nb);
        int n;
        chk("in_ready_before_beat", {31'd0, bus_a.in_ready}, 32'd1);
        valid = 1'b1; data = d; sop = s; eop = e; nbytes = nb;
        if (s) begin
            pkt.delete();
            in_pkt = 1'b1;
        end
        if (in_pkt) begin
            n = e ? eff_bytes(nb) : 4;
            for (int k = 0; k < n; k++) pkt.push_back(d[31-8*k -: 8]);
            if (e) in_pkt = 1'b0;
        end
        tick();
        valid = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    // Called one cycle after the eop beat was accepted.
    task automatic finish_pkt(input string nm, input logic [15:0] exp_a, input int stall);
        logic [15:0] eb, ec;
        eb = model_crc(16'hFFFF);
        ec = model_crc(16'h1D0F) ^ 16'hFFFF;
        chk({nm, "_valid_a"}, {31'd0, bus_a.crc_valid}, 32'd1);
        chk({nm, "_valid_c"}, {31'd0, bus_c.crc_valid}, 32'd1);
        chk({nm, "_crc_a"}, {16'd0, bus_a.crc_out}, {16'd0, exp_a});
        chk({nm, "_crc_b"}, {16'd0, bus_b.crc_out}, {16'd0, eb});
        chk({nm, "_crc_c"}, {16'd0, bus_c.crc_out}, {16'd0, ec});
        for (int s = 0; s < stall; s++) begin
            chk({nm, "_stall_ready"}, {31'd0, bus_b.in_ready}, 32'd0);
            tick();
            chk({nm, "_stall_valid"}, {31'd0, bus_b.crc_valid}, 32'd1);
            chk({nm, "_stall_crc_b"}, {16'd0, bus_b.crc_out}, {16'd0, eb});
        end
        cready = 1'b1;
        chk({nm, "_consume_ready"}, {31'd0, bus_a.in_ready}, 32'd0);
        tick();
        cready = 1'b0;
        chk({nm, "_after_valid"}, {31'd0, bus_a.crc_valid}, 32'd0);
        chk({nm, "_after_ready"}, {31'd0, bus_a.in_ready}, 32'd1);
    endtask

    // ---------------- single-beat vectors for the INIT=0 engine --------------
    typedef struct {
        logic [31:0] d;
        logic [2:0]  nb;
        logic [15:0] exp_a;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{32'h0000_0001, 3'd4, 16'h100B};
        tbl[1] = '{32'h01AA_BBCC, 3'd1, 16'h100B};
        tbl[2] = '{32'h0000_0001, 3'd0, 16'h100B};
        tbl[3] = '{32'h0000_0001, 3'd5, 16'h100B};
        tbl[4] = '{32'h0001_0000, 3'd2, 16'h100B};
        tbl[5] = '{32'h0000_01FF, 3'd3, 16'h100B};
        tbl[6] = '{32'h0000_0002, 3'd4, 16'h2016};
        tbl[7] = '{32'h0000_0003, 3'd4, 16'h301D};
        tbl[8] = '{32'h0000_0000, 3'd4, 16'h0000};

        // Reset is asynchronous: outputs settle with no clock edge.
        #1;
        chk("rst_in_ready", {31'd0, bus_a.in_ready}, 32'd0);
        chk("rst_crc_valid", {31'd0, bus_a.crc_valid}, 32'd0);
        chk("rst_crc_out", {16'd0, bus_b.crc_out}, 32'd0);
        chk("rst_crc_err", {31'd0, bus_a.crc_err}, 32'd0);
        tick(); tick();
        rst = 1'b1;
        chk("rel_ready_before_edge", {31'd0, bus_a.in_ready}, 32'd0);
        tick();
        chk("rel_ready_after_edge", {31'd0, bus_a.in_ready}, 32'd1);

        foreach (tbl[i]) begin
            send_beat(tbl[i].d, 1'b1, 1'b1, tbl[i].nb);
            finish_pkt($sformatf("vec%0d", i), tbl[i].exp_a, 0);
        end

        // Gap of 3 idle cycles inside a packet.
        send_beat(32'h0, 1'b1, 1'b0, 3'd4);
        repeat (3) begin
            tick();
            chk("gap_no_valid", {31'd0, bus_a.crc_valid}, 32'd0);
        end
        send_beat(32'h0000_0001, 1'b0, 1'b1, 3'd4);
        finish_pkt("gap", 16'h100B, 0);

        // Stall with a competing beat offered during HOLD; it must be ignored.
        send_beat(32'hDEAD_BEEF, 1'b1, 1'b1, 3'd4);
        valid = 1'b1; sop = 1'b1; eop = 1'b1; data = 32'h1234_5678;
        repeat (5) begin
            chk("hold_ready", {31'd0, bus_b.in_ready}, 32'd0);
            tick();
        end
        valid = 1'b0; sop = 1'b0; eop = 1'b0;
        finish_pkt("stall", model_crc(16'h0000), 0);

        // Orphan beat in IDLE.
        send_beat(32'h1234_5678, 1'b0, 1'b1, 3'd4);
        chk("orphan_err", {31'd0, bus_a.crc_err}, 32'd1);
        chk("orphan_no_valid", {31'd0, bus_a.crc_valid}, 32'd0);
        tick();
        chk("orphan_err_pulse", {31'd0, bus_a.crc_err}, 32'd0);
        chk("orphan_still_idle", {31'd0, bus_a.crc_valid}, 32'd0);

        // Restart inside a packet.
        send_beat(32'hFFFF_FFFF, 1'b1, 1'b0, 3'd4);
        chk("accum_no_err", {31'd0, bus_a.crc_err}, 32'd0);
        send_beat(32'h0000_0001, 1'b1, 1'b1, 3'd4);
        chk("restart_err", {31'd0, bus_a.crc_err}, 32'd1);
        finish_pkt("restart", 16'h100B, 1);
        chk("restart_err_low", {31'd0, bus_a.crc_err}, 32'd0);

        // Reset in the middle of a packet.
        send_beat(32'hA5A5_A5A5, 1'b1, 1'b0, 3'd4);
        rst = 1'b0;
        #1;
        pkt.delete(); in_pkt = 1'b0;
        chk("mid_rst_ready", {31'd0, bus_a.in_ready}, 32'd0);
        chk("mid_rst_valid", {31'd0, bus_a.crc_valid}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        repeat (3) begin
            chk("mid_rst_no_valid", {31'd0, bus_a.crc_valid}, 32'd0);
            tick();
        end
        send_beat(32'h0000_0001, 1'b0, 1'b1, 3'd4);   // IDLE rejects a non-sop beat
        chk("mid_rst_idle_err", {31'd0, bus_a.crc_err}, 32'd1);
        send_beat(32'h0000_0001, 1'b1, 1'b1, 3'd4);
        finish_pkt("post_rst", 16'h100B, 0);

        // Reset while a result is held drops it at once.
        send_beat(32'h0000_0001, 1'b1, 1'b1, 3'd4);
        chk("hold_rst_pre", {31'd0, bus_a.crc_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("hold_rst_valid", {31'd0, bus_a.crc_valid}, 32'd0);
        chk("hold_rst_crc", {16'd0, bus_b.crc_out}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Random packets against the model.
        for (int p = 0; p < 40; p++) begin
            int nbeats;
            nbeats = int'($urandom_range(1, 3));
            for (int b = 0; b < nbeats; b++) begin
                send_beat($urandom, (b == 0), (b == nbeats - 1), 3'($urandom_range(0, 7)));
                repeat ($urandom_range(0, 2)) begin
                    if (b != nbeats - 1) tick();
                end
            end
            finish_pkt($sformatf("rnd%0d", p), model_crc(16'h0000), int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
